// File: rtl/burst_mem_pkg.sv
// Shared definitions for the burst memory controller: FSM state encoding and
// default parameter values.
package burst_mem_pkg;

  localparam int DEF_DW         = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LAT        = 8;
  localparam int DEF_HS         = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_ACK,
    WR_DATA,
    WR_DONE,
    LATENCY,
    RD_DRIVE,
    RD_RELEASE
  } state_e;

endpackage

// File: rtl/burst_mem_array.sv
// Word storage behind the controller: 2**DW words of DW bits, written on the
// clock edge and read combinationally.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [DW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**DW];

  // No reset on purpose: contents must survive a controller reset.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/burst_mem_ctrl.sv
// Handshaked line-burst memory controller on a shared address/data bus.
// Define BURST_WRAP_EN for critical-word-first bursts that wrap within the line.
module burst_mem_ctrl
  import burst_mem_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LAT        = DEF_LAT,
  parameter int HS         = DEF_HS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rrqst,
  input  logic          wrqst,
  input  logic          rdacpt,
  output logic          rrdy,
  output logic          rdrdy,
  output logic          wacpt,
  inout  wire  [DW-1:0] data
);

  localparam int IW   = $clog2(LINE_WORDS);
  localparam int CMAX = (LAT > HS) ? LAT : HS;
  localparam int CW   = $clog2(CMAX + 1);

  state_e        state_q;
  logic          wt_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] beat_q;
  logic [DW-1:0] addr_q;
  logic          rdLine_q;
  logic          wrOp_q;
  logic          rrdy_q;
  logic          rdrdy_q;
  logic          wacpt_q;

  logic          hsDone;
  logic          latDone;
  logic          ackReq;
  logic          memWe;
  logic [DW-1:0] rdData;

  assign cnt_d   = cnt_q + CW'(1);
  assign hsDone  = (cnt_q == CW'(HS - 1));
  assign latDone = (cnt_q == CW'(LAT - 1));
  assign ackReq  = wrOp_q ? wrqst : rrqst;
  assign memWe   = (state_q == WR_DATA) && wt_q && hsDone;

  burst_mem_array #(.DW(DW)) u_array (
    .clock   (clock),
    .we_i    (memWe),
    .waddr_i (addr_q),
    .wdata_i (data),
    .raddr_i ({addr_q[DW-1:IW], idx_q}),
    .rdata_o (rdData)
  );

  // wt_q marks the HS wait that precedes every handshake edge we produce.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wt_q     <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      rdLine_q <= 1'b0;
      wrOp_q   <= 1'b0;
      rrdy_q   <= 1'b0;
      rdrdy_q  <= 1'b0;
      wacpt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!wt_q) begin
            if (rrqst || wrqst) begin
              wt_q     <= 1'b1;
              cnt_q    <= '0;
              rdLine_q <= rrqst;
              wrOp_q   <= wrqst;
            end
          end else if (hsDone) begin
            wt_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= data;
            beat_q  <= '0;
`ifdef BURST_WRAP_EN
            idx_q   <= data[IW-1:0];
`else
            idx_q   <= '0;
`endif
            state_q <= ADDR_ACK;
            if (wrOp_q) wacpt_q <= 1'b1;
            else        rrdy_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ADDR_ACK: begin
          if (!wt_q) begin
            wt_q  <= !ackReq;
            cnt_q <= '0;
          end else if (hsDone) begin
            wt_q    <= 1'b0;
            cnt_q   <= '0;
            rrdy_q  <= 1'b0;
            wacpt_q <= 1'b0;
            state_q <= wrOp_q ? WR_DATA : LATENCY;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WR_DATA: begin
          if (!wt_q) begin
            wt_q  <= wrqst;
            cnt_q <= '0;
          end else if (hsDone) begin
            wt_q    <= 1'b0;
            cnt_q   <= '0;
            wacpt_q <= 1'b1;
            state_q <= WR_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WR_DONE: begin
          if (!wt_q) begin
            wt_q  <= !wrqst;
            cnt_q <= '0;
          end else if (hsDone) begin
            wt_q    <= 1'b0;
            cnt_q   <= '0;
            wacpt_q <= 1'b0;
            state_q <= rdLine_q ? LATENCY : IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        LATENCY: begin
          if (latDone) begin
            cnt_q   <= '0;
            state_q <= RD_DRIVE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        // First word waits HS before rdrdy; later words arrive with rdrdy already set.
        RD_DRIVE: begin
          if (!rdrdy_q) begin
            if (hsDone) begin
              rdrdy_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (!wt_q) begin
            wt_q  <= rdacpt;
            cnt_q <= '0;
          end else if (hsDone) begin
            wt_q    <= 1'b0;
            cnt_q   <= '0;
            rdrdy_q <= 1'b0;
            state_q <= RD_RELEASE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RD_RELEASE: begin
          if (!wt_q) begin
            wt_q  <= !rdacpt;
            cnt_q <= '0;
          end else if (hsDone) begin
            wt_q  <= 1'b0;
            cnt_q <= '0;
            idx_q <= idx_q + IW'(1);
            if (beat_q == IW'(LINE_WORDS - 1)) begin
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              beat_q  <= beat_q + IW'(1);
              rdrdy_q <= 1'b1;
              state_q <= RD_DRIVE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rrdy  = rrdy_q;
  assign rdrdy = rdrdy_q;
  assign wacpt = wacpt_q;
  assign data  = rdrdy_q ? rdData : {DW{1'bz}};

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Self-checking bench for burst_mem_ctrl: the bench plays the cache and checks
// bursts against a word-addressed reference memory. Honours BURST_WRAP_EN.
module tb_burst_mem_ctrl;

  localparam int DW  = 16;
  localparam int LW  = 4;
  localparam int LAT = 8;
  localparam int HS  = 2;
  localparam int SEL_RRDY  = 0;
  localparam int SEL_RDRDY = 1;
  localparam int SEL_WACPT = 2;
  localparam int BOUND = 200;

  logic          clock  = 1'b0;
  logic          reset  = 1'b0;
  logic          rrqst  = 1'b0;
  logic          wrqst  = 1'b0;
  logic          rdacpt = 1'b0;
  logic          rrdy;
  logic          rdrdy;
  logic          wacpt;
  wire  [DW-1:0] data;
  logic          tbDrive = 1'b0;
  logic [DW-1:0] tbData  = '0;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCnt    = 0;
  int wacptRises  = 0;
  int rdrdyRises  = 0;
  logic prevW = 1'b0;
  logic prevR = 1'b0;
  logic [DW-1:0] refMem [int];

  assign data = tbDrive ? tbData : {DW{1'bz}};

  burst_mem_ctrl #(.DW(DW), .LINE_WORDS(LW), .LAT(LAT), .HS(HS)) dut (
    .clock  (clock),
    .reset  (reset),
    .rrqst  (rrqst),
    .wrqst  (wrqst),
    .rdacpt (rdacpt),
    .rrdy   (rrdy),
    .rdrdy  (rdrdy),
    .wacpt  (wacpt),
    .data   (data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, actual, expected, cycleCnt);
    end
  endtask

  // Acknowledge exclusivity every cycle, plus pulse counting.
  always @(negedge clock) begin
    checkOutput("onehot_acks", 32'($countones({rrdy, rdrdy, wacpt}) <= 1), 32'd1);
    if (wacpt && !prevW) wacptRises++;
    if (rdrdy && !prevR) rdrdyRises++;
    prevW = wacpt;
    prevR = rdrdy;
  end

  function automatic logic sigVal(input int sel);
    case (sel)
      SEL_RRDY:  return rrdy;
      SEL_RDRDY: return rdrdy;
      default:   return wacpt;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitSig(input int sel, input logic val, input string tag);
    int n = 0;
    while (sigVal(sel) !== val && n < BOUND) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(sigVal(sel)), 32'(val));
  endtask

  // Address of burst position k for a request at address a.
  function automatic logic [DW-1:0] burstAddr(input logic [DW-1:0] a, input int k);
    int start;
    logic [DW-1:0] base;
    base = a & ~DW'(LW - 1);
`ifdef BURST_WRAP_EN
    start = int'(a % LW);
`else
    start = 0;
`endif
    return base + DW'((start + k) % LW);
  endfunction

  task automatic doWrite(input logic [DW-1:0] addr, input logic [DW-1:0] wd, input bit miss);
    tbData  = addr;
    tbDrive = 1'b1;
    rrqst   = miss;
    wrqst   = 1'b1;
    waitSig(SEL_WACPT, 1'b1, "wr_addr_ack");
    idle($urandom_range(0, 2));
    wrqst = 1'b0;
    rrqst = 1'b0;
    waitSig(SEL_WACPT, 1'b0, "wr_addr_drop");
    tbData = wd;
    idle($urandom_range(0, 2));
    wrqst = 1'b1;
    waitSig(SEL_WACPT, 1'b1, "wr_data_ack");
    idle($urandom_range(0, 2));
    wrqst   = 1'b0;
    tbDrive = 1'b0;
    waitSig(SEL_WACPT, 1'b0, "wr_data_drop");
    refMem[int'(addr)] = wd;
  endtask

  task automatic doReadReq(input logic [DW-1:0] addr, output int fallCycle);
    tbData  = addr;
    tbDrive = 1'b1;
    rrqst   = 1'b1;
    waitSig(SEL_RRDY, 1'b1, "rd_addr_ack");
    idle($urandom_range(0, 2));
    rrqst   = 1'b0;
    tbDrive = 1'b0;
    waitSig(SEL_RRDY, 1'b0, "rd_addr_drop");
    fallCycle = cycleCnt;
  endtask

  // Receive one line burst; optionally reset at abortBeat or hold rdacpt at holdBeat.
  task automatic collectBurst(input logic [DW-1:0] addr, input int fallCycle, input bit chkLat,
                              input int abortBeat, input int holdBeat);
    logic [DW-1:0] a;
    int falls;
    int rises;
    logic prev;
    for (int k = 0; k < LW; k++) begin
      waitSig(SEL_RDRDY, 1'b1, "rd_valid");
      if (k == 0 && chkLat) checkOutput("rd_latency", 32'(cycleCnt - fallCycle), 32'(LAT + HS));
      a = burstAddr(addr, k);
      if (refMem.exists(int'(a))) checkOutput($sformatf("rd_word%0d_@%0h", k, a), 32'(data), 32'(refMem[int'(a)]));
      if (k == abortBeat) begin
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("abort_rrdy", 32'(rrdy), 32'd0);
        checkOutput("abort_rdrdy", 32'(rdrdy), 32'd0);
        checkOutput("abort_wacpt", 32'(wacpt), 32'd0);
        rdacpt = 1'b0;
        @(negedge clock);
        return;
      end
      if (k == holdBeat) begin
        rdacpt = 1'b1;
        falls  = 0;
        rises  = 0;
        prev   = 1'b1;
        repeat (20) begin
          @(negedge clock);
          if (prev && !rdrdy) falls++;
          if (!prev && rdrdy) rises++;
          prev = rdrdy;
        end
        checkOutput("hold_falls", 32'(falls), 32'd1);
        checkOutput("hold_rises", 32'(rises), 32'd0);
        rdacpt = 1'b0;
      end else begin
        idle($urandom_range(0, 3));
        rdacpt = 1'b1;
        waitSig(SEL_RDRDY, 1'b0, "rd_release");
        idle($urandom_range(0, 3));
        rdacpt = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int nOps);
    int op;
    int fc;
    logic [DW-1:0] addr;
    logic [DW-1:0] wd;
    for (int i = 0; i < 32; i++) doWrite(DW'(16'h0100 + i), DW'($urandom), 1'b0);
    for (int i = 0; i < nOps; i++) begin
      op   = $urandom_range(0, 2);
      addr = DW'(16'h0100 + $urandom_range(0, 31));
      wd   = DW'($urandom);
      case (op)
        0: begin
          doReadReq(addr, fc);
          collectBurst(addr, fc, 1'b1, -1, -1);
        end
        1: doWrite(addr, wd, 1'b0);
        default: begin
          doWrite(addr, wd, 1'b1);
          collectBurst(addr, 0, 1'b0, -1, -1);
        end
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fc;
    int w0;
    int r0;
    repeat (3) @(negedge clock);
    checkOutput("rst_rrdy", 32'(rrdy), 32'd0);
    checkOutput("rst_rdrdy", 32'(rdrdy), 32'd0);
    checkOutput("rst_wacpt", 32'(wacpt), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 4; i++) doWrite(DW'(16'h0040 + i), DW'(16'h00A0 + i), 1'b0);
    doReadReq(16'h0042, fc);
    collectBurst(16'h0042, fc, 1'b1, -1, -1);

    w0 = wacptRises;
    doWrite(16'h0010, 16'h1234, 1'b0);
    checkOutput("wacpt_pulses", 32'(wacptRises - w0), 32'd2);
    doReadReq(16'h0010, fc);
    collectBurst(16'h0010, fc, 1'b1, -1, -1);

    for (int i = 0; i < 4; i++) doWrite(DW'(16'h0080 + i), DW'($urandom), 1'b0);
    r0 = rdrdyRises;
    doWrite(16'h0081, 16'hBEEF, 1'b1);
    collectBurst(16'h0081, 0, 1'b0, -1, -1);
    checkOutput("wmiss_rdrdy_pulses", 32'(rdrdyRises - r0), 32'd4);

    doReadReq(16'h0040, fc);
    collectBurst(16'h0040, fc, 1'b0, 2, -1);
    idle(2);
    reset = 1'b1;
    idle(1);
    doReadReq(16'h0042, fc);
    collectBurst(16'h0042, fc, 1'b1, -1, -1);

    doReadReq(16'h0040, fc);
    collectBurst(16'h0040, fc, 1'b1, -1, 1);

    applyStimulus(24);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
